// File: rtl/rv_lsu_pkg.sv
// Shared types and helpers for the rv_lsu load/store unit: FSM states, access sizes,
// funct3 encodings, byte-enable generation and load extension.
package rv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        B = 2'd0,
        H = 2'd1,
        W = 2'd2,
        D = 2'd3
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam int         F3_UNS_BIT = 2;

    // Byte enables for an access of the given size starting at byte lane addr_lsb.
    function automatic logic [7:0] be_mask(input lsu_size_e size, input logic [2:0] addr_lsb);
        logic [7:0] base;
        case (size)
            B:       base = 8'h01;
            H:       base = 8'h03;
            W:       base = 8'h0F;
            D:       base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << addr_lsb;
    endfunction

    function automatic logic [63:0] sext_load(input logic [63:0] data, input lsu_size_e size,
                                              input logic uns);
        logic [63:0] res;
        case (size)
            B:       res = uns ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
            H:       res = uns ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
            W:       res = uns ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
            D:       res = data;
            default: res = 64'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv_lsu_lane.sv
// Combinational byte-lane steering: store data trimmed to size and shifted into its lane,
// load data shifted down from its lane and sign/zero-extended.
module rv_lsu_lane
    import rv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_size_e                   st_size,
    input  logic [$clog2(XLEN/8)-1:0]   st_lane,
    input  logic [XLEN-1:0]             st_data,
    input  lsu_size_e                   ld_size,
    input  logic [$clog2(XLEN/8)-1:0]   ld_lane,
    input  logic                        ld_uns,
    input  logic [XLEN-1:0]             ld_raw,
    output logic [XLEN-1:0]             st_lanes,
    output logic [XLEN-1:0]             ld_ext
);

    logic [XLEN-1:0] st_mask_s;
    logic [XLEN-1:0] ld_shift_s;

    // Trim store data to the access size, then place both directions in their lanes.
    always_comb begin
        st_mask_s = '0;
        case (st_size)
            B:       st_mask_s = XLEN'(64'h0000_0000_0000_00FF);
            H:       st_mask_s = XLEN'(64'h0000_0000_0000_FFFF);
            W:       st_mask_s = XLEN'(64'h0000_0000_FFFF_FFFF);
            D:       st_mask_s = XLEN'(64'hFFFF_FFFF_FFFF_FFFF);
            default: st_mask_s = '0;
        endcase
        st_lanes   = (st_data & st_mask_s) << {st_lane, 3'b000};
        ld_shift_s = ld_raw >> {ld_lane, 3'b000};
        ld_ext     = XLEN'(sext_load(64'(ld_shift_s), ld_size, ld_uns));
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: one request per handshake, req/ack bus transaction with timeout.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses respond with err instead of aligning down.
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_base,
    input  logic [11:0]         req_offset,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [XLEN-1:0]     bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_ack,
    input  logic [XLEN-1:0]     bus_rdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_data,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    lsu_size_e          size_r;
    logic [OFF_W-1:0]   lane_r;
    logic               uns_r;
    logic               store_r;

    lsu_size_e          size_s;
    logic [XLEN-1:0]    eff_addr_s;
    logic [XLEN-1:0]    aligned_addr_s;
    logic [2:0]         low_mask_s;
    logic [OFF_W-1:0]   lane_s;
    logic               illegal_s;
    logic               err_s;
    logic               timeout_s;
    logic [XLEN-1:0]    st_lanes_s;
    logic [XLEN-1:0]    ld_ext_s;
`ifdef LSU_MISALIGN_TRAP_EN
    logic               misalign_s;
`endif

    // Decode the incoming request: effective address, alignment and legality.
    always_comb begin
        size_s     = lsu_size_e'(req_funct3[1:0]);
        eff_addr_s = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};
        case (size_s)
            B:       low_mask_s = 3'b000;
            H:       low_mask_s = 3'b001;
            W:       low_mask_s = 3'b011;
            D:       low_mask_s = 3'b111;
            default: low_mask_s = 3'b000;
        endcase
        aligned_addr_s = eff_addr_s & ~{{(XLEN-3){1'b0}}, low_mask_s};
        lane_s         = aligned_addr_s[OFF_W-1:0];
        illegal_s      = ((size_s == D) && (XLEN == 32)) || (req_store && req_funct3[F3_UNS_BIT]);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = |(eff_addr_s[2:0] & low_mask_s);
        err_s      = illegal_s || misalign_s;
`else
        err_s      = illegal_s;
`endif
        timeout_s = (TIMEOUT_CYC != 0) && (cnt_r == CNT_LAST);
    end

    rv_lsu_lane #(
        .XLEN (XLEN)
    ) u_lane (
        .st_size  (size_s),
        .st_lane  (lane_s),
        .st_data  (req_wdata),
        .ld_size  (size_r),
        .ld_lane  (lane_r),
        .ld_uns   (uns_r),
        .ld_raw   (bus_rdata),
        .st_lanes (st_lanes_s),
        .ld_ext   (ld_ext_s)
    );

    // IDLE -> BUS -> RESP -> IDLE sequencer with all interface outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            size_r    <= B;
            lane_r    <= '0;
            uns_r     <= 1'b0;
            store_r   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        size_r    <= size_s;
                        lane_r    <= lane_s;
                        uns_r     <= req_funct3[F3_UNS_BIT];
                        store_r   <= req_store;
                        rsp_data  <= '0;
                        if (err_s) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_r   <= BUS;
                            cnt_r     <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= req_store;
                            bus_addr  <= {aligned_addr_s[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            bus_be    <= BE_W'(be_mask(size_s, 3'(lane_s)));
                            bus_wdata <= st_lanes_s;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                BUS: begin
                    // Ack has priority over a timeout landing in the same cycle.
                    if (bus_ack || timeout_s) begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !bus_ack;
                        rsp_data  <= (bus_ack && !store_r) ? ld_ext_s : '0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= '0;
                        bus_wdata <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r   <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    bus_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
